// File: rtl/versatile_fifo_pkg.sv
// rtl/versatile_fifo_pkg.sv - shared pointer helpers for the versatile FIFO controllers
//
// Purpose: pointer width and pointer-distance helpers used by both the
// read-side and write-side controllers, plus the capture-destination
// encoding of the read-side output buffer.
// Ports: none (package).
package versatile_fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 9;
    localparam int DEFAULT_PTR_W      = DEFAULT_ADDR_WIDTH + 1;

    // Widest pointer the distance helper supports; callers zero-extend into it.
    localparam int MAX_PTR_W = 32;

    // Where a word arriving from the RAM lands in the 2-entry output buffer.
    typedef enum logic [1:0] {
        CAP_NONE = 2'd0,
        CAP_HEAD = 2'd1,
        CAP_SKID = 2'd2
    } cap_dst_e;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // (a - b) mod 2**ptr_w. With the wrap bit included, a full-depth
    // difference of 2**(ptr_w-1) stays distinct from zero.
    function automatic logic [MAX_PTR_W-1:0] ptr_diff(
        input logic [MAX_PTR_W-1:0] a,
        input logic [MAX_PTR_W-1:0] b,
        input int                   ptr_w
    );
        logic [MAX_PTR_W-1:0] mask;
        if (ptr_w >= MAX_PTR_W) begin
            mask = '1;
        end else begin
            mask = (MAX_PTR_W'(1) << ptr_w) - MAX_PTR_W'(1);
        end
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/versatile_fifo_skid2.sv
// rtl/versatile_fifo_skid2.sv - 2-entry registered output buffer for the FIFO read side
//
// Purpose: holds up to two words (head = dout, plus one skid entry) so the
// read side can keep one RAM read in flight while the consumer stalls.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data word captured from the RAM this cycle
//   dout, dout_valid head-of-queue word and its valid (both registered)
//   dout_ready      consumer accepts dout this cycle
//   pop             dout_valid & dout_ready, exported for the issue logic
//   buf_cnt         number of words held, 0..2
module versatile_fifo_skid2
    import versatile_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  pop,
    output logic [1:0]            buf_cnt
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    cap_dst_e              dst;

    always_comb begin
        pop    = valid_q & dout_ready;
        head_d = head_q;
        skid_d = skid_q;
        dst    = CAP_NONE;

        // A new word goes straight to the head only if the head is free at
        // this edge: buffer empty, or the single held word is leaving now.
        if (push) begin
            if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
                dst = CAP_HEAD;
            end else begin
                dst = CAP_SKID;
            end
        end

        if (pop && cnt_q == 2'd2) begin
            head_d = skid_q;
        end

        case (dst)
            CAP_HEAD: head_d = push_data;
            CAP_SKID: skid_d = push_data;
            default:  ;
        endcase

        cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign dout       = head_q;
    assign dout_valid = valid_q;
    assign buf_cnt    = cnt_q;

endmodule

// File: rtl/versatile_fifo_fwft_reader.sv
// rtl/versatile_fifo_fwft_reader.sv - first-word-fall-through read controller for the versatile FIFO
//
// Purpose: issues reads on the RAM B port (one-cycle read latency), buffers
// the returned words and presents them as a valid/ready stream at one word
// per clock. rd_ptr is the release pointer the write side uses for full.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_ptr            write pointer from the write side (wrap bit in MSB)
//   adr_b, q_b        RAM B-port address and read data (data one cycle later)
//   dout, dout_valid  head word and valid
//   dout_ready        consumer accepts dout
//   rd_ptr            count of words captured out of the RAM
//   empty, count      occupancy status
module versatile_fifo_fwft_reader
    import versatile_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH-1:0] adr_b,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] count
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int CNT_W = ADDR_WIDTH + 2;

    logic [PTR_W-1:0] iss_ptr_q, iss_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] avail;
    logic [2:0]       occ;
    logic             issue;
    logic             pop;
    logic [1:0]       buf_cnt;

    always_comb begin
        avail = PTR_W'(ptr_diff(MAX_PTR_W'(wr_ptr), MAX_PTR_W'(iss_ptr_q), PTR_W));

        // Slots committed after this edge: held words plus the word arriving
        // now, minus the one leaving. An issue is allowed only if its data
        // is guaranteed a slot when it returns.
        occ   = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (avail != '0) && (occ < 3'd2);

        iss_ptr_d  = iss_ptr_q + PTR_W'(issue);
        inflight_d = issue;

        // Release at capture, not issue: the slot stays protected from the
        // writer until its data has left q_b.
        rd_ptr_d = rd_ptr_q + PTR_W'(inflight_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            iss_ptr_q  <= iss_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    versatile_fifo_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .push_data  (q_b),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .pop        (pop),
        .buf_cnt    (buf_cnt)
    );

    assign adr_b  = iss_ptr_q[ADDR_WIDTH-1:0];
    assign rd_ptr = rd_ptr_q;

    // wr_ptr - rd_ptr covers words still in RAM including the one in flight;
    // buf_cnt covers words already captured. Both terms come from flops, so
    // the status moves on the same edge as the state it describes.
    assign empty = (wr_ptr == rd_ptr_q) && !dout_valid;
    assign count = CNT_W'(ptr_diff(MAX_PTR_W'(wr_ptr), MAX_PTR_W'(rd_ptr_q), PTR_W))
                 + CNT_W'(buf_cnt);

endmodule

// File: tb/tb_versatile_fifo_fwft_reader.sv
// tb/tb_versatile_fifo_fwft_reader.sv - self-checking bench for versatile_fifo_fwft_reader
module tb_versatile_fifo_fwft_reader;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] adr_b;
    logic [DW-1:0] q_b;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic [AW+1:0] count;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    int tests = 0;
    int fails = 0;
    int n_wr  = 0;

    logic          prev_hold;
    logic [DW-1:0] prev_dout;

    versatile_fifo_fwft_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_ptr     (wr_ptr),
        .adr_b      (adr_b),
        .q_b        (q_b),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rd_ptr     (rd_ptr),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Write side + RAM model: write and wr_ptr advance on the same edge,
    // B-port read data appears one cycle after the address is sampled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + 1'b1;
        end
    end

    always @(posedge clk) begin
        q_b <= mem[adr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        n_wr++;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard and stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(dout_valid), 32'd1);
                chk("hold_data", 32'(dout), 32'(prev_dout));
            end
            if (dout_valid && dout_ready) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL spurious_word: observed 0x%0h expected no word", dout);
                end
                if (exp_q.size() != 0) begin
                    chk("order", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
            prev_hold <= dout_valid && !dout_ready;
            prev_dout <= dout;
        end
    end

    initial begin
        int base;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        dout_ready = 1'b0;
        prev_hold  = 1'b0;
        repeat (2) step();

        // Reset values while held in reset
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_adr_b", 32'(adr_b), 32'd0);
        chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
        rst_n      = 1'b1;
        dout_ready = 1'b1;

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_valid", 32'(dout_valid), 32'd0);
            chk("idle_empty", 32'(empty), 32'd1);
            chk("idle_rd_ptr", 32'(rd_ptr), 32'd0);
            chk("idle_count", 32'(count), 32'd0);
            chk("idle_adr_b", 32'(adr_b), 32'd0);
        end

        // Single word: dout_valid two edges after the write edge
        put(8'hA5);
        chk("lat_e0_valid", 32'(dout_valid), 32'd0);
        step();
        chk("lat_e1_valid", 32'(dout_valid), 32'd0);
        step();
        chk("lat_e2_valid", 32'(dout_valid), 32'd1);
        chk("lat_e2_dout", 32'(dout), 32'hA5);
        chk("lat_e2_rd_ptr", 32'(rd_ptr), 32'd1);
        chk("lat_e2_count", 32'(count), 32'd1);
        step();
        chk("single_after_valid", 32'(dout_valid), 32'd0);
        chk("single_after_empty", 32'(empty), 32'd1);
        chk("single_after_rd_ptr", 32'(rd_ptr), 32'd1);
        chk("single_after_count", 32'(count), 32'd0);

        // 8 words preloaded, then streamed with no bubbles
        dout_ready = 1'b0;
        base = n_wr;
        for (int i = 0; i < 8; i++) put(8'(i));
        repeat (3) step();
        chk("pre8_count", 32'(count), 32'd8);
        chk("pre8_rd_ptr", 32'(rd_ptr), 32'((base + 2) % 16));
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 32'(dout_valid), 32'd1);
            chk("stream_dout", 32'(dout), 32'(i));
            step();
        end
        chk("stream_done_valid", 32'(dout_valid), 32'd0);
        chk("stream_done_empty", 32'(empty), 32'd1);

        // Backpressure: 4 words, consumer stalled for 10 cycles
        dout_ready = 1'b0;
        base = n_wr;
        for (int i = 0; i < 4; i++) put(8'h40 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(dout_valid), 32'd1);
            chk("stall_dout", 32'(dout), 32'h40);
            step();
        end
        chk("stall_rd_ptr", 32'(rd_ptr), 32'((base + 2) % 16));
        chk("stall_count", 32'(count), 32'd4);
        chk("stall_adr_b", 32'(adr_b), 32'((base + 2) % DEPTH));
        dout_ready = 1'b1;
        wait_drain(100);
        step();
        chk("stall_drained_empty", 32'(empty), 32'd1);

        // Wrap: fresh pointers, RAM full plus both buffer slots held
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        n_wr = 0;
        dout_ready = 1'b0;
        step();
        for (int i = 0; i < 10; i++) put(8'h80 + 8'(i));
        repeat (3) step();
        chk("full_count", 32'(count), 32'(DEPTH + 2));
        chk("full_empty", 32'(empty), 32'd0);
        chk("full_rd_ptr", 32'(rd_ptr), 32'd2);
        chk("full_wr_minus_rd", 32'(4'(wr_ptr - rd_ptr)), 32'(DEPTH));
        chk("full_dout", 32'(dout), 32'h80);
        dout_ready = 1'b1;
        wait_drain(100);
        for (int i = 0; i < 6; i++) put(8'h90 + 8'(i));
        wait_drain(100);
        repeat (2) step();
        chk("wrap_rd_ptr", 32'(rd_ptr), 32'd0);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_count", 32'(count), 32'd0);

        // Asynchronous reset with a word buffered and a read in flight
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) put(8'hC0 + 8'(i));
        chk("pre_rst_valid", 32'(dout_valid), 32'd1);
        chk("pre_rst_rd_ptr", 32'(rd_ptr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_rd_ptr", 32'(rd_ptr), 32'd0);
        chk("arst_adr_b", 32'(adr_b), 32'd0);
        exp_q.delete();
        step();
        rst_n      = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_valid", 32'(dout_valid), 32'd0);
        end
        put(8'h5A);
        wait_drain(20);
        step();
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
